isa_mem_write_capture: RTL

- Upstream of the VRAM write buffer.
- Watches the asynchronous ISA memory-write cycle and synchronizes MEMW#, SBHE# and the address/data buses into the `clock` domain.
- Decodes the card's memory window and emits one clean, stretched write strobe per accepted ISA write, with stable 20-bit address, 16-bit data and byte enables.
- Holds the ISA cycle off via IOCHRDY when the buffer is near full.

---
 rtl/isa_mem_write_capture.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/isa_mem_write_capture.sv
// isa_mem_write_capture
//   Captures asynchronous ISA memory-write cycles that fall in the card's memory window. For
//   each accepted write it produces one stretched write strobe to the VRAM write buffer,
//   together with a stable address, data word and byte lanes. When the buffer reports
//   almost-full, the ISA cycle is held off through IOCHRDY for a bounded time.
//
// Ports
//   clock            system fast clock
//   RESET            synchronous, active-high reset
//   isa_sa[19:0]     ISA address bus (asynchronous)
//   isa_sd[15:0]     ISA data bus (asynchronous)
//   isa_memw_n       ISA MEMW# (asynchronous)
//   isa_sbhe_n       ISA SBHE# (asynchronous)
//   buf_almost_full  buffer cannot safely take another entry
//   buf_full         buffer full
//   data_out[15:0]   captured write data
//   addr_out[19:0]   captured byte address
//   byte_en[1:0]     [0] low lane, [1] high lane, active high
//   new_data         write strobe, high for STROBE_CYCLES cycles
//   iochrdy_pull     1 = pull ISA IOCHRDY low (wait)
//   dropped          one-cycle pulse when a write is discarded
//
// Optional build macro ISA_CAPTURE_STATS_EN adds the saturating counters stat_writes,
// stat_drops and stat_waits (16 bits each, cleared by RESET).

module isa_mem_write_capture #(
  parameter logic [19:0] WIN_BASE      = 20'hA0000,
  parameter logic [19:0] WIN_SIZE      = 20'h20000,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned STROBE_CYCLES = 3,
  parameter int unsigned WAIT_MAX      = 200
) (
  input  logic        clock,
  input  logic        RESET,
  input  logic [19:0] isa_sa,
  input  logic [15:0] isa_sd,
  input  logic        isa_memw_n,
  input  logic        isa_sbhe_n,
  input  logic        buf_almost_full,
  input  logic        buf_full,
  output logic [15:0] data_out,
  output logic [19:0] addr_out,
  output logic [1:0]  byte_en,
  output logic        new_data,
  output logic        iochrdy_pull,
  output logic        dropped
`ifdef ISA_CAPTURE_STATS_EN
  ,
  output logic [15:0] stat_writes,
  output logic [15:0] stat_drops,
  output logic [15:0] stat_waits
`endif
);

  typedef enum logic [2:0] {StIdle, StSettle, StCheck, StWait, StStrobe, StRelease} state_e;

  localparam logic [15:0] SettleMax = 16'(SETTLE_CYCLES);
  localparam logic [15:0] StrobeMax = 16'(STROBE_CYCLES);
  localparam logic [15:0] WaitMax   = 16'(WAIT_MAX);

  // Two-flop synchronizers; control lines reset to their inactive (high) level.
  logic [19:0] r_sa_s1, r_sa_s2;
  logic [15:0] r_sd_s1, r_sd_s2;
  logic        r_memw_s1, r_memw_s2;
  logic        r_sbhe_s1, r_sbhe_s2;

  always_ff @(posedge clock) begin
    if (RESET) begin
      r_sa_s1   <= '0;
      r_sa_s2   <= '0;
      r_sd_s1   <= '0;
      r_sd_s2   <= '0;
      r_memw_s1 <= 1'b1;
      r_memw_s2 <= 1'b1;
      r_sbhe_s1 <= 1'b1;
      r_sbhe_s2 <= 1'b1;
    end else begin
      r_sa_s1   <= isa_sa;
      r_sa_s2   <= r_sa_s1;
      r_sd_s1   <= isa_sd;
      r_sd_s2   <= r_sd_s1;
      r_memw_s1 <= isa_memw_n;
      r_memw_s2 <= r_memw_s1;
      r_sbhe_s1 <= isa_sbhe_n;
      r_sbhe_s2 <= r_sbhe_s1;
    end
  end

  logic w_memw_low;
  assign w_memw_low = ~r_memw_s2;

  // Window decode on 21-bit values so base+size never wraps past 20'hFFFFF.
  logic [20:0] w_sa_ext, w_win_lo, w_win_hi;
  logic        w_hit;
  assign w_sa_ext = {1'b0, r_sa_s2};
  assign w_win_lo = {1'b0, WIN_BASE};
  assign w_win_hi = {1'b0, WIN_BASE} + {1'b0, WIN_SIZE};
  assign w_hit    = (w_sa_ext >= w_win_lo) && (w_sa_ext < w_win_hi);

  // Lane steering: an 8-bit cycle at an odd address with SBHE# high lands on the low lane.
  logic [1:0]  w_be;
  logic [15:0] w_data;
  always_comb begin
    w_be = {~r_sbhe_s2, ~r_sa_s2[0]};
    if (w_be == 2'b00) w_be = 2'b01;
    w_data = r_sd_s2;
    if (w_be == 2'b10) w_data = {r_sd_s2[15:8], r_sd_s2[15:8]};
  end

  state_e      r_state, w_state_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic        w_capture, w_drop, w_strobe_start, w_wait_start;

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_capture      = 1'b0;
    w_drop         = 1'b0;
    w_strobe_start = 1'b0;
    w_wait_start   = 1'b0;
    case (r_state)
      StIdle: begin
        // The cycle that detects MEMW# low already counts as the first settle cycle.
        if (w_memw_low) begin
          w_state_d = (SETTLE_CYCLES <= 1) ? StCheck : StSettle;
          w_cnt_d   = 16'd1;
        end
      end
      StSettle: begin
        if (!w_memw_low) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else if (r_cnt + 16'd1 >= SettleMax) begin
          w_state_d = StCheck;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StCheck: begin
        w_cnt_d = 16'd1;
        if (!w_hit) begin
          w_state_d = StRelease;
          w_cnt_d   = '0;
        end else begin
          w_capture = 1'b1;
          if (buf_almost_full) begin
            w_state_d    = StWait;
            w_wait_start = 1'b1;
          end else begin
            w_state_d      = StStrobe;
            w_strobe_start = 1'b1;
          end
        end
      end
      StWait: begin
        if (!buf_almost_full || (r_cnt >= WaitMax && !buf_full)) begin
          w_state_d      = StStrobe;
          w_cnt_d        = 16'd1;
          w_strobe_start = 1'b1;
        end else if (r_cnt >= WaitMax) begin
          w_state_d = StRelease;
          w_cnt_d   = '0;
          w_drop    = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StStrobe: begin
        if (r_cnt >= StrobeMax) begin
          w_state_d = StRelease;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StRelease: begin
        // One strobe per ISA cycle: wait here until MEMW# returns high.
        if (!w_memw_low) w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  logic [15:0] r_data;
  logic [19:0] r_addr;
  logic [1:0]  r_be;
  logic        r_dropped;

  always_ff @(posedge clock) begin
    if (RESET) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_data    <= '0;
      r_addr    <= '0;
      r_be      <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_dropped <= w_drop;
      if (w_capture) begin
        r_data <= w_data;
        r_addr <= r_sa_s2;
        r_be   <= w_be;
      end
    end
  end

  assign data_out     = r_data;
  assign addr_out     = r_addr;
  assign byte_en      = r_be;
  assign new_data     = (r_state == StStrobe);
  assign iochrdy_pull = (r_state == StWait);
  assign dropped      = r_dropped;

`ifdef ISA_CAPTURE_STATS_EN
  logic [15:0] r_stat_writes, r_stat_drops, r_stat_waits;

  always_ff @(posedge clock) begin
    if (RESET) begin
      r_stat_writes <= '0;
      r_stat_drops  <= '0;
      r_stat_waits  <= '0;
    end else begin
      if (w_strobe_start && r_stat_writes != 16'hFFFF) r_stat_writes <= r_stat_writes + 16'd1;
      if (w_drop && r_stat_drops != 16'hFFFF) r_stat_drops <= r_stat_drops + 16'd1;
      if (w_wait_start && r_stat_waits != 16'hFFFF) r_stat_waits <= r_stat_waits + 16'd1;
    end
  end

  assign stat_writes = r_stat_writes;
  assign stat_drops  = r_stat_drops;
  assign stat_waits  = r_stat_waits;
`endif

endmodule
